bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Replaces fixed-width combinational range-compare conversion for wide values on the display path: scores, timers, counters feeding the 7-segment digit mux.
- Valid/ready handshake on both sides.
- Saturating overflow, plus a leading-zero blanking mask for the display driver.

Parameters:
- BIN_W, 16: binary input width, 1..32.
- DIGITS, 5: number of BCD output digits, 1..10.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  bin is valid.
- in_ready  out  1  converter can accept a value.
- bin  in  BIN_W  unsigned binary value.
- out_valid  out  1  bcd, overflow and digit_nz are valid.
- out_ready  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  packed BCD; digit 0 (ones) in [3:0].
- overflow  out  1  bin exceeded 10^DIGITS-1; bcd saturated.
- digit_nz  out  DIGITS  bit i = 1 when digit i is not a leading zero.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, bcd=0, overflow=0, digit_nz=1 (bit 0 only), bit counter=0, shift register=0.
- Reset mid-conversion aborts immediately and discards any held result.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load bin into the shift register, clear the BCD accumulator, counter=0.
  - Register ovf_pend = (bin > MAXDEC), where MAXDEC = 10^DIGITS-1. ovf_pend is constant 0 when MAXDEC >= 2^BIN_W-1.
  - Go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge: every BCD digit >= 5 gets +3, then the {bcd, bin} register shifts left 1. Carry out of the top digit is ignored; overflow is covered by ovf_pend.
  - Counter increments each edge. After BIN_W shift edges, go to DONE.
- DONE:
  - out_valid=1 and outputs are held stable.
  - Outputs are registered on entry to DONE. If ovf_pend: bcd = all digits 9, overflow=1. Otherwise bcd = accumulator, overflow=0.
  - digit_nz[i] = 1 iff some digit j >= i is nonzero. digit_nz[0] is always 1. Computed at DONE entry.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
- Latency: out_valid rises BIN_W edges after the accepting edge.
- in_valid is ignored outside IDLE. Minimum period between accepts is BIN_W+2 cycles.
- bin is sampled only on the accepting edge. Later changes to bin have no effect.
- out_ready held high produces a 1-cycle out_valid pulse.
- Unbounded backpressure in DONE holds the result indefinitely.
- bin=0 → bcd=0, digit_nz=…0001.
- Width rules: the accumulator is 4*DIGITS bits. Add-3 is applied to 4-bit digits only. Comparison uses a BIN_W+1 bit unsigned compare against the MAXDEC constant, truncated safely when MAXDEC overflows BIN_W bits.
- Elaboration error when BIN_W or DIGITS is out of range.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Function pow10_minus1(n) for MAXDEC.
  - Function clog2 for the counter width.
  - Constant BCD_DIGIT_W=4.
- One sub-module bcd_add3 (4-bit in, 4-bit out: +3 if >=5), instantiated DIGITS times via generate.
- The FSM, shift register and blanking logic stay in bin_to_bcd_seq.

Test Plan:
- Defaults, bin=0 → after 16 cycles bcd=20'h00000, overflow=0, digit_nz=5'b00001.
- Defaults, bin=65535 → bcd=20'h65535, digit_nz=5'b11111, out_valid exactly 16 edges after accept.
- Defaults, bin=59 → bcd=20'h00059, digit_nz=5'b00011. Hold out_ready=0 for 10 cycles: outputs stable and in_ready=0. Release: returns to IDLE, next accept works.
- BIN_W=8, DIGITS=2, bin=100 → overflow=1, bcd=8'h99. With bin=99 → overflow=0, bcd=8'h99. With bin=63 → 8'h63.
- Defaults, assert rst on the 7th SHIFT cycle → same cycle: out_valid=0, in_ready=1. A new bin=1234 completes as 20'h01234 with no residue from the aborted value.
- Random back-to-back stream of 1000 values, in_valid always 1, random out_ready → every output matches a reference decimal model, and no value is dropped or duplicated.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest value representable with n decimal digits (10^n - 1).
  function automatic longint unsigned pow10_minus1(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  // Ceiling log2, minimum result 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Digits >= 5 would become >= 10 after the next shift, so pre-correct them.
  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3),
// valid/ready on both sides, saturating overflow and leading-zero mask.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_nz
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = clog2(BIN_W + 1);
  localparam longint unsigned MAXDEC  = pow10_minus1(DIGITS);
  localparam longint unsigned BIN_MAX = (64'd1 << BIN_W) - 64'd1;
  // Overflow can only happen when the binary range exceeds the decimal range.
  localparam bit OVF_POSSIBLE = (MAXDEC < BIN_MAX);
  // When overflow is possible MAXDEC fits in BIN_W bits; otherwise the value is unused.
  localparam logic [BIN_W:0] MAXDEC_T = OVF_POSSIBLE ? MAXDEC[BIN_W:0] : {(BIN_W+1){1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Parameter range guards.
  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be in 1..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS must be in 1..10");
  end

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    bcd_q, bcd_d;
  logic                overflow_q, overflow_d;
  logic [DIGITS-1:0]   digit_nz_q, digit_nz_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BIN_W-1:0]    sh_q, sh_d;
  logic                ovf_pend_q, ovf_pend_d;

  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_shift;
  logic [BIN_W-1:0]    sh_shift;
  logic [ACC_W-1:0]    bcd_final;
  logic [DIGITS-1:0]   nz_chain;
  logic [DIGITS-1:0]   nz_final;
  logic                ovf_in;

  // Add-3 correction on every accumulator digit ahead of the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .d (acc_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // {acc, sh} shifted left by one; the top-digit carry falls off by design.
  assign acc_shift = {acc_adj[ACC_W-2:0], sh_q[BIN_W-1]};
  assign sh_shift  = sh_q << 1;

  // Result presented on entry to DONE: saturate to all nines on overflow.
  assign bcd_final = ovf_pend_q ? {DIGITS{4'h9}} : acc_shift;

  // Blanking mask: digit i is shown when it or any more significant digit is nonzero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
    if (gi == DIGITS - 1) begin : g_top
      assign nz_chain[gi] = |bcd_final[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
    end else begin : g_lower
      assign nz_chain[gi] = nz_chain[gi+1] | (|bcd_final[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end
  assign nz_final = nz_chain | DIGITS'(1);

  assign ovf_in = OVF_POSSIBLE && ({1'b0, bin} > MAXDEC_T);

  // Next-state logic for the FSM, datapath and registered outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bcd_d       = bcd_q;
    overflow_d  = overflow_q;
    digit_nz_d  = digit_nz_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    ovf_pend_d  = ovf_pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d       = bin;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = ovf_in;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sh_d  = sh_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          bcd_d       = bcd_final;
          overflow_d  = ovf_pend_q;
          digit_nz_d  = nz_final;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      digit_nz_q  <= DIGITS'(1);
      cnt_q       <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      ovf_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bcd_q       <= bcd_d;
      overflow_q  <= overflow_d;
      digit_nz_q  <= digit_nz_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      ovf_pend_q  <= ovf_pend_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign overflow  = overflow_q;
  assign digit_nz  = digit_nz_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and streamed checks of bin_to_bcd_seq at default size and at 8-bit/2-digit.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-size instance (16 bits, 5 digits)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_overflow;
  logic [15:0] a_bin;
  logic [19:0] a_bcd;
  logic [4:0]  a_digit_nz;

  // Small instance (8 bits, 2 digits)
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_overflow;
  logic [7:0]  b_bin;
  logic [7:0]  b_bcd;
  logic [1:0]  b_digit_nz;

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(a_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd(a_bcd), .overflow(a_overflow), .digit_nz(a_digit_nz)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd(b_bcd), .overflow(b_overflow), .digit_nz(b_digit_nz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: repeated divide by ten, no shift-and-add.
  function automatic logic [19:0] ref_bcd5(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_nz5(input logic [19:0] b);
    logic [4:0] r;
    logic seen;
    seen = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (b[4*i +: 4] != 4'd0) seen = 1'b1;
      r[i] = seen;
    end
    r[0] = 1'b1;
    return r;
  endfunction

  // Accept one value on instance A and count edges until out_valid.
  task automatic a_convert(input logic [15:0] v, output int lat);
    @(negedge clk);
    check("a_in_ready_before_accept", a_in_ready, 1);
    a_bin = v;
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_bin = 16'hA5A5;
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic a_release();
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("a_out_valid_after_release", a_out_valid, 0);
    check("a_in_ready_after_release", a_in_ready, 1);
    a_out_ready = 1'b0;
  endtask

  task automatic b_convert(input logic [7:0] v, output int lat);
    @(negedge clk);
    check("b_in_ready_before_accept", b_in_ready, 1);
    b_bin = v;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_bin = 8'h5A;
    lat = 0;
    while (!b_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic b_release();
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("b_out_valid_after_release", b_out_valid, 0);
    b_out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int sent, got, cyc;
    int q[$];
    int exp_v;
    logic [15:0] nxt;
    logic ir, ov, ovf_s;
    logic [19:0] bcd_s, exp_bcd;
    logic [4:0] nz_s;

    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_bin = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = '0;
    #1;
    // Reset state
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_bcd", a_bcd, 0);
    check("rst_overflow", a_overflow, 0);
    check("rst_digit_nz", a_digit_nz, 5'b00001);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // bin = 0
    a_convert(16'd0, lat);
    check("zero_latency", lat, 16);
    check("zero_bcd", a_bcd, 20'h00000);
    check("zero_overflow", a_overflow, 0);
    check("zero_digit_nz", a_digit_nz, 5'b00001);
    a_release();

    // bin = 65535, full width
    a_convert(16'd65535, lat);
    check("max_latency", lat, 16);
    check("max_bcd", a_bcd, 20'h65535);
    check("max_digit_nz", a_digit_nz, 5'b11111);
    check("max_overflow", a_overflow, 0);
    a_release();

    // bin = 59 with 10 cycles of backpressure
    a_convert(16'd59, lat);
    check("hold_latency", lat, 16);
    check("hold_bcd", a_bcd, 20'h00059);
    check("hold_digit_nz", a_digit_nz, 5'b00011);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_bcd_stable", a_bcd, 20'h00059);
      check("hold_out_valid", a_out_valid, 1);
      check("hold_in_ready", a_in_ready, 0);
    end
    a_release();
    a_convert(16'd1000, lat);
    check("after_hold_bcd", a_bcd, 20'h01000);
    check("after_hold_digit_nz", a_digit_nz, 5'b01111);
    a_release();

    // Small instance: overflow boundary
    b_convert(8'd100, lat);
    check("b100_latency", lat, 8);
    check("b100_bcd", b_bcd, 8'h99);
    check("b100_overflow", b_overflow, 1);
    check("b100_digit_nz", b_digit_nz, 2'b11);
    b_release();
    b_convert(8'd99, lat);
    check("b99_bcd", b_bcd, 8'h99);
    check("b99_overflow", b_overflow, 0);
    b_release();
    b_convert(8'd63, lat);
    check("b63_bcd", b_bcd, 8'h63);
    check("b63_overflow", b_overflow, 0);
    b_release();
    b_convert(8'd5, lat);
    check("b5_bcd", b_bcd, 8'h05);
    check("b5_digit_nz", b_digit_nz, 2'b01);
    b_release();
    b_convert(8'd255, lat);
    check("b255_bcd", b_bcd, 8'h99);
    check("b255_overflow", b_overflow, 1);
    b_release();

    // Reset in the 7th shift cycle, then a clean conversion
    @(negedge clk);
    a_bin = 16'd54321;
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", a_out_valid, 0);
    check("abort_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    a_convert(16'd1234, lat);
    check("abort_next_latency", lat, 16);
    check("abort_next_bcd", a_bcd, 20'h01234);
    check("abort_next_digit_nz", a_digit_nz, 5'b01111);
    a_release();

    // Streamed values, random out_ready, decimal reference
    sent = 0; got = 0; cyc = 0;
    nxt = 16'($urandom_range(0, 65535));
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      a_bin = nxt;
      a_in_valid = (sent < 1000);
      a_out_ready = 1'($urandom_range(0, 1));
      #1;
      ir = a_in_ready; ov = a_out_valid;
      bcd_s = a_bcd; nz_s = a_digit_nz; ovf_s = a_overflow;
      @(posedge clk);
      cyc++;
      if (ir && a_in_valid) begin
        q.push_back(int'(nxt));
        sent++;
        nxt = 16'($urandom_range(0, 65535));
      end
      if (ov && a_out_ready) begin
        if (q.size() == 0) begin
          check("stream_spurious_output", 1, 0);
        end else begin
          exp_v = q.pop_front();
          exp_bcd = ref_bcd5(exp_v);
          check("stream_bcd", bcd_s, exp_bcd);
          check("stream_digit_nz", nz_s, ref_nz5(exp_bcd));
          check("stream_overflow", ovf_s, 0);
        end
        got++;
      end
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    check("stream_received", got, 1000);
    check("stream_sent", sent, 1000);
    check("stream_leftover", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
